// File: rtl/lpf_frame_sequencer.sv
// Job controller for the 3x3 low-pass filter core: launches the core per frame
// with a fixed reset window, watches the output stream for framing/completion,
// and guards each RUN phase with an idle-beat watchdog.
module lpf_frame_sequencer #(
   parameter int XB      = 10,
   parameter int YB      = 10,
   parameter int FB      = 8,
   parameter int RST_CYC = 8,
   parameter int TOB     = 16,
   parameter int TO_CYC  = 65535
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [XB-1:0] cmd_width,
   input  logic [YB-1:0] cmd_height,
   input  logic [FB-1:0] cmd_frames,
   input  logic          abort,
   output logic          flt_rst,
   output logic [XB-1:0] flt_cfg_width,
   output logic [YB-1:0] flt_cfg_height,
   input  logic          mon_valid,
   input  logic          mon_ready,
   input  logic          mon_last_x,
   input  logic          mon_last_y,
   input  logic          flt_done,
   output logic          busy,
   output logic [FB-1:0] frame_idx,
   output logic          frame_done,
   output logic          job_done,
   output logic          err_framing,
   output logic          err_timeout
);

   localparam int RCB = $clog2(RST_CYC + 1);

   typedef enum logic [1:0] {S_IDLE, S_RST, S_RUN} state_t;

   state_t          state_reg, state_next;
   logic [FB-1:0]   frames_reg;
   logic [RCB-1:0]  rst_cnt_reg, rst_cnt_next;
   logic [XB-1:0]   x_reg, x_next;
   logic [YB-1:0]   y_reg, y_next;
   logic [TOB-1:0]  wd_reg, wd_next;
   logic            all_seen_reg, all_seen_next;

   logic            flt_rst_next, busy_next, frame_done_next, job_done_next;
   logic            err_framing_next, err_timeout_next;
   logic [FB-1:0]   frame_idx_next;

   // Per-cycle decode of the handshake tap and counter positions
   logic beat, accept, at_x_end, at_y_end, final_beat, seen_now;
   logic frame_complete, last_frame, rst_end, timeout, bad_beat;

   assign cmd_ready      = (state_reg == S_IDLE);
   assign accept         = cmd_valid && cmd_ready;
   assign beat           = mon_valid && mon_ready;
   assign at_x_end       = (x_reg == flt_cfg_width);
   assign at_y_end       = (y_reg == flt_cfg_height);
   assign final_beat     = beat && at_x_end && at_y_end;
   assign seen_now       = all_seen_reg || final_beat;
   assign frame_complete = (state_reg == S_RUN) && flt_done && seen_now;
   assign last_frame     = (frame_idx == frames_reg);
   assign rst_end        = (state_reg == S_RST) && (rst_cnt_reg == RCB'(RST_CYC - 1));
   assign timeout        = (state_reg == S_RUN) && !beat && !frame_complete &&
                           (wd_reg == TOB'(TO_CYC - 1));
   assign bad_beat       = beat && ((mon_last_x != at_x_end) || (mon_last_y != at_y_end));

   // State and output/datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= S_IDLE;
         flt_rst        <= 1'b1;
         flt_cfg_width  <= '0;
         flt_cfg_height <= '0;
         frames_reg     <= '0;
         busy           <= 1'b0;
         frame_idx      <= '0;
         frame_done     <= 1'b0;
         job_done       <= 1'b0;
         err_framing    <= 1'b0;
         err_timeout    <= 1'b0;
         rst_cnt_reg    <= '0;
         x_reg          <= '0;
         y_reg          <= '0;
         wd_reg         <= '0;
         all_seen_reg   <= 1'b0;
      end else begin
         state_reg    <= state_next;
         flt_rst      <= flt_rst_next;
         busy         <= busy_next;
         frame_idx    <= frame_idx_next;
         frame_done   <= frame_done_next;
         job_done     <= job_done_next;
         err_framing  <= err_framing_next;
         err_timeout  <= err_timeout_next;
         rst_cnt_reg  <= rst_cnt_next;
         x_reg        <= x_next;
         y_reg        <= y_next;
         wd_reg       <= wd_next;
         all_seen_reg <= all_seen_next;
         if (accept) begin
            flt_cfg_width  <= cmd_width;
            flt_cfg_height <= cmd_height;
            frames_reg     <= cmd_frames;
         end
      end
   end

   // Next-state: abort dominates, then frame completion, then watchdog
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE: if (cmd_valid) state_next = S_RST;
         S_RST: begin
            if (abort)        state_next = S_IDLE;
            else if (rst_end) state_next = S_RUN;
         end
         S_RUN: begin
            if (abort)               state_next = S_IDLE;
            else if (frame_complete) state_next = last_frame ? S_IDLE : S_RST;
            else if (timeout)        state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Output and counter next values; core is held in reset outside RUN
   always_comb begin
      flt_rst_next     = (state_next != S_RUN);
      busy_next        = (state_next != S_IDLE);
      frame_done_next  = frame_complete && !abort;
      job_done_next    = frame_complete && !abort && last_frame;
      err_framing_next = err_framing;
      err_timeout_next = err_timeout;
      frame_idx_next   = frame_idx;
      rst_cnt_next     = (state_reg == S_RST) ? rst_cnt_reg + 1'b1 : '0;
      x_next           = x_reg;
      y_next           = y_reg;
      wd_next          = wd_reg;
      all_seen_next    = all_seen_reg;

      if (accept) begin
         err_framing_next = 1'b0;
         err_timeout_next = 1'b0;
         frame_idx_next   = '0;
      end else if (state_reg == S_RUN && !abort) begin
         // Early done is flagged but the frame keeps waiting for its pixels
         if (bad_beat || (flt_done && !seen_now)) err_framing_next = 1'b1;
         if (timeout) err_timeout_next = 1'b1;
         if (frame_complete && !last_frame) frame_idx_next = frame_idx + 1'b1;
      end

      if (state_reg != S_RUN) begin
         x_next        = '0;
         y_next        = '0;
         wd_next       = '0;
         all_seen_next = 1'b0;
      end else if (beat) begin
         x_next        = at_x_end ? '0 : x_reg + 1'b1;
         if (at_x_end) y_next = at_y_end ? '0 : y_reg + 1'b1;
         wd_next       = '0;
         all_seen_next = seen_now;
      end else begin
         wd_next = wd_reg + 1'b1;
      end
   end

endmodule

// File: tb/tb_lpf_frame_sequencer.sv
// Directed bench for lpf_frame_sequencer; frame_done/job_done pulses are
// checked against a scoreboard queue filled as final beats are driven.
module tb_lpf_frame_sequencer;

   localparam int XB = 10, YB = 10, FB = 8;

   logic          clk, rst_n;
   logic          cmd_valid, cmd_ready;
   logic [XB-1:0] cmd_width, flt_cfg_width;
   logic [YB-1:0] cmd_height, flt_cfg_height;
   logic [FB-1:0] cmd_frames, frame_idx;
   logic          abort, flt_rst;
   logic          mon_valid, mon_ready, mon_last_x, mon_last_y, flt_done;
   logic          busy, frame_done, job_done, err_framing, err_timeout;

   int tests_run    = 0;
   int tests_failed = 0;

   typedef struct packed {
      logic [FB-1:0] fidx;
      logic          job;
   } exp_t;
   exp_t sb_q[$];

   lpf_frame_sequencer #(.XB(XB), .YB(YB), .FB(FB), .RST_CYC(8), .TOB(16), .TO_CYC(100)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_width(cmd_width), .cmd_height(cmd_height), .cmd_frames(cmd_frames),
      .abort(abort), .flt_rst(flt_rst),
      .flt_cfg_width(flt_cfg_width), .flt_cfg_height(flt_cfg_height),
      .mon_valid(mon_valid), .mon_ready(mon_ready),
      .mon_last_x(mon_last_x), .mon_last_y(mon_last_y), .flt_done(flt_done),
      .busy(busy), .frame_idx(frame_idx), .frame_done(frame_done), .job_done(job_done),
      .err_framing(err_framing), .err_timeout(err_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to the next falling edge and retire any completion pulse
   task automatic tick();
      exp_t e;
      @(negedge clk);
      if (frame_done || job_done) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_pulse", {30'd0, frame_done, job_done}, 32'd0);
         end else begin
            e = sb_q.pop_front();
            chk("pulse_frame_done", frame_done, 1);
            chk("pulse_frame_idx", frame_idx, e.fidx);
            chk("pulse_job_done", job_done, e.job);
         end
      end
   endtask

   task automatic clear_mon();
      mon_valid = 0; mon_ready = 0; mon_last_x = 0; mon_last_y = 0; flt_done = 0;
   endtask

   task automatic send_cmd(input int w, input int h, input int f);
      cmd_valid = 1; cmd_width = XB'(w); cmd_height = YB'(h); cmd_frames = FB'(f);
      tick();
      cmd_valid = 0;
      chk("acc_busy", busy, 1);
      chk("acc_cmd_ready", cmd_ready, 0);
      chk("acc_cfg_w", flt_cfg_width, w);
      chk("acc_cfg_h", flt_cfg_height, h);
      chk("acc_frame_idx", frame_idx, 0);
      chk("acc_err_framing", err_framing, 0);
      chk("acc_err_timeout", err_timeout, 0);
   endtask

   // flt_rst high for the 8 cycles after entering RST, low from the 8th edge
   task automatic rst_window();
      chk("rstwin_hi", flt_rst, 1);
      for (int i = 1; i < 8; i++) begin
         tick();
         chk("rstwin_hi", flt_rst, 1);
      end
      tick();
      chk("rstwin_lo", flt_rst, 0);
   endtask

   // Raster-order frame; bad = beat number whose last_x is inverted (-1 none)
   task automatic send_frame(input int w, input int h, input int bad,
                             input int idx_after, input bit job, input bit late);
      exp_t e;
      for (int y = 0; y <= h; y++) begin
         for (int x = 0; x <= w; x++) begin
            mon_valid  = 1;
            mon_ready  = 1;
            mon_last_x = (x == w);
            mon_last_y = (y == h);
            if (y * (w + 1) + x == bad) mon_last_x = ~mon_last_x;
            if (x == w && y == h && !late) begin
               flt_done = 1;
               e.fidx = FB'(idx_after); e.job = job;
               sb_q.push_back(e);
            end
            tick();
         end
      end
      clear_mon();
      if (late) begin
         flt_done = 1;
         e.fidx = FB'(idx_after); e.job = job;
         sb_q.push_back(e);
         tick();
         flt_done = 0;
      end
   endtask

   initial begin
      rst_n = 0; cmd_valid = 0; cmd_width = 0; cmd_height = 0; cmd_frames = 0; abort = 0;
      clear_mon();
      tick(); tick();
      // Reset state
      chk("rst_flt_rst", flt_rst, 1);
      chk("rst_cfg_w", flt_cfg_width, 0);
      chk("rst_cfg_h", flt_cfg_height, 0);
      chk("rst_busy", busy, 0);
      chk("rst_frame_idx", frame_idx, 0);
      chk("rst_pulses", {frame_done, job_done}, 0);
      chk("rst_errs", {err_framing, err_timeout}, 0);
      chk("rst_cmd_ready", cmd_ready, 1);
      rst_n = 1;
      tick();

      // Single 4x3 frame, done with the final beat
      send_cmd(3, 2, 0);
      rst_window();
      send_frame(3, 2, -1, 0, 1, 0);
      chk("t1_busy", busy, 0);
      chk("t1_cmd_ready", cmd_ready, 1);
      chk("t1_errs", {err_framing, err_timeout}, 0);
      chk("t1_sb_empty", sb_q.size(), 0);

      // Three 1x1 frames
      send_cmd(0, 0, 2);
      for (int f = 0; f < 3; f++) begin
         rst_window();
         chk("t2_frame_idx", frame_idx, f);
         send_frame(0, 0, -1, (f == 2) ? 2 : f + 1, f == 2, 0);
      end
      chk("t2_busy", busy, 0);
      chk("t2_errs", {err_framing, err_timeout}, 0);
      chk("t2_sb_empty", sb_q.size(), 0);

      // Bad last_x on beat 4; frame completes with a late done
      send_cmd(3, 2, 0);
      rst_window();
      send_frame(3, 2, 3, 0, 1, 1);
      chk("t3_err_framing", err_framing, 1);
      chk("t3_busy", busy, 0);
      chk("t3_sb_empty", sb_q.size(), 0);
      send_cmd(1, 0, 0);
      chk("t3_err_cleared", err_framing, 0);
      // Abort during RST
      tick(); tick();
      abort = 1;
      tick();
      abort = 0;
      chk("t4_rst_abort_ready", cmd_ready, 1);
      chk("t4_rst_abort_flt_rst", flt_rst, 1);
      chk("t4_rst_abort_busy", busy, 0);
      tick();
      chk("t4_abort_ignored_idle", cmd_ready, 1);

      // Watchdog with no beats
      send_cmd(2, 2, 0);
      rst_window();
      repeat (99) tick();
      chk("t5_no_timeout_yet", err_timeout, 0);
      chk("t5_still_run", flt_rst, 0);
      tick();
      chk("t5_err_timeout", err_timeout, 1);
      chk("t5_flt_rst", flt_rst, 1);
      chk("t5_cmd_ready", cmd_ready, 1);
      chk("t5_sb_empty", sb_q.size(), 0);

      // Abort mid-RUN with a stalled cycle in between beats
      send_cmd(2, 0, 0);
      rst_window();
      mon_valid = 1; mon_ready = 1; mon_last_x = 0; mon_last_y = 1;
      tick();
      mon_ready = 0; mon_last_x = 1;
      tick();
      mon_ready = 1; mon_last_x = 0;
      tick();
      clear_mon();
      abort = 1;
      tick();
      abort = 0;
      chk("t6_cmd_ready", cmd_ready, 1);
      chk("t6_flt_rst", flt_rst, 1);
      chk("t6_busy", busy, 0);
      chk("t6_stall_no_advance", err_framing, 0);
      chk("t6_sb_empty", sb_q.size(), 0);

      // Asynchronous reset during frame 1
      send_cmd(1, 0, 1);
      rst_window();
      send_frame(1, 0, -1, 1, 0, 0);
      rst_window();
      chk("t7_frame_idx", frame_idx, 1);
      mon_valid = 1; mon_ready = 1; mon_last_x = 0; mon_last_y = 1;
      tick();
      clear_mon();
      #2 rst_n = 0;
      #1;
      chk("t7_arst_flt_rst", flt_rst, 1);
      chk("t7_arst_busy", busy, 0);
      chk("t7_arst_frame_idx", frame_idx, 0);
      chk("t7_arst_cfg_w", flt_cfg_width, 0);
      chk("t7_arst_cmd_ready", cmd_ready, 1);
      tick();
      rst_n = 1;
      tick();
      send_cmd(0, 0, 0);
      rst_window();
      send_frame(0, 0, -1, 0, 1, 0);
      chk("t7_busy", busy, 0);
      chk("t7_sb_empty", sb_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
